puzzle_shuffler: RTL and testbench
==================================

// Module: puzzle_shuffler
// PURPOSE
//   Upstream of the move engine. On a start request it loads the solved 3x3 board and scrambles it.
//   It applies exactly N_MOVES random legal blank moves, one per clock, driven by a free-running LFSR.
//   The board is only ever changed by legal moves, so the result is always solvable.
//   row1..row3 feed the move engine's Row1..Row3 inputs. The engine may act only while busy==0.
// PARAMETERS
//   N_MOVES    64        number of moves per shuffle, >=1
//   LFSR_SEED  16'hACE1  LFSR reset value, must be nonzero
// PORTS
//   clk        in   1   system clock, all state on rising edge
//   rst_n      in   1   asynchronous reset, active-low
//   start      in   1   shuffle request (single-cycle pulse from the debounced centre button)
//   row1       out  12  top row; [11:8]=left col, [7:4]=mid col, [3:0]=right col; 4'h0 = blank
//   row2       out  12  middle row, same layout
//   row3       out  12  bottom row, same layout
//   blank_pos  out  4   blank index p = 3*row + col (0..8), row 0 = top, col 0 = left
//   busy       out  1   high while shuffling
//   done       out  1   one-cycle pulse when the shuffle completes
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     row1=12'h123, row2=12'h456, row3=12'h780 (solved board); blank_pos=8; busy=0; done=0.
//     lfsr=LFSR_SEED; cnt=0; prev_dir=NONE; state=IDLE.
//   LFSR:
//     16-bit Fibonacci, x^16+x^14+x^13+x^11+1.
//     Every cycle outside reset: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
//     It free-runs in all states, so button timing supplies the entropy.
//   Directions (blank motion): 0=L (col-1), 1=R (col+1), 2=U (row-1), 3=D (row+1).
//     reverse(dir) = dir ^ 2'b01.
//     Legal: L col>0, R col<2, U row>0, D row<2.
//   Move select (combinational from current lfsr[1:0] and blank position):
//     Try lfsr[1:0], then +1, +2, +3 (mod 4).
//     Take the first candidate that is legal and not reverse(prev_dir); prev_dir=NONE excludes nothing.
//     Every cell has >=2 legal moves, so a choice always exists.
//   Move:
//     The tile at the target cell is written into the blank's cell; the target cell becomes 4'h0.
//     blank_pos <= target index; prev_dir <= chosen dir.
//   FSM states: IDLE, SHUFFLE.
//     IDLE & start:
//       board <= solved, blank_pos <= 8, prev_dir <= NONE, cnt <= 0, busy <= 1 -> SHUFFLE.
//       No move is applied in this cycle.
//     SHUFFLE, every cycle: apply one move, cnt <= cnt+1.
//       On the cycle cnt==N_MOVES-1: apply the last move, busy <= 0, done <= 1 -> IDLE.
//     Latency: busy is high for exactly N_MOVES cycles.
//       done pulses in the cycle after the last move, while busy is already 0, and lasts one cycle.
//   Boundary conditions:
//     - start while busy: ignored, no restart, no queuing.
//     - start in the cycle done is high: accepted (state is IDLE).
//     - start held high: a new shuffle is re-triggered each time IDLE is reached.
//     - rst_n low mid-shuffle: immediate return to reset values (solved board, busy=0, no done).
//     - While busy=0, rows and blank_pos hold their value.
//     - At all times the nine nibbles hold each of 0..8 exactly once.
//     - cnt is sized $clog2(N_MOVES+1) bits; no wrap is reachable.
// TESTING
//   1 Reset -> rows 123/456/780, blank_pos=8, busy=0, done=0; lfsr steps from 16'hACE1 to 16'h59C3.
//   2 N_MOVES=64, pulse start -> busy high exactly 64 cycles, done high 1 cycle right after.
//     Every busy cycle: rows are a permutation of 0..8, blank moves exactly one adjacent step, no immediate reversal.
//   3 N_MOVES=1, start -> final board is 123/450/786 (blank_pos=5) or 123/456/708 (blank_pos=7).
//     The choice must match the bench model for the sampled lfsr[1:0].
//   4 Pulse start again at cycle 10 of a 64-move shuffle -> ignored; done still comes after move 64.
//   5 rst_n low at move 30 -> solved board and busy=0 asynchronously; no done pulse.
//     A later start then runs a full 64 moves.
//   6 Two back-to-back shuffles (start coincident with done) -> second begins from the solved board.
//     Bench LFSR model matches all moves in both shuffles.

Source files
------------

// File: rtl/puzzle_shuffler.sv
// puzzle_shuffler: on a start request, loads the solved 3x3 board and scrambles it
// with exactly N_MOVES legal blank moves, one per clock. Each move is picked from a
// free-running LFSR, so the timing of the button press supplies the randomness. The
// board only changes through legal moves, so the result is always solvable.
module puzzle_shuffler #(
  parameter int          N_MOVES   = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [11:0] row1,
  output logic [11:0] row2,
  output logic [11:0] row3,
  output logic [3:0]  blank_pos,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = $clog2(N_MOVES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_MOVES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [3:0] BLANK_HOME = 4'd8;

  // Cell p holds board_r[p]; cell 0 is top-left and cell 8 is bottom-right.
  localparam logic [8:0][3:0] SOLVED = {4'h0, 4'h8, 4'h7, 4'h6, 4'h5,
                                        4'h4, 4'h3, 4'h2, 4'h1};

  // Blank motion directions; reversing a move flips bit 0.
  localparam logic [1:0] DIR_L = 2'd0;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_U = 2'd2;
  localparam logic [1:0] DIR_D = 2'd3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    SHUFFLE = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [15:0]     lfsr_r;
  logic [8:0][3:0] board_r;
  logic [8:0][3:0] board_mv_s;
  logic [3:0]      blank_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]      prev_dir_r;
  logic            prev_valid_r;
  logic            busy_r;
  logic            done_r;
  logic            load_s;
  logic            move_s;
  logic            last_s;
  logic [1:0]      dir_s;
  logic [3:0]      tgt_s;
  logic [3:0]      tgt_tile_s;

  // Row index (0 = top) of a cell index.
  function automatic logic [1:0] pos_row(input logic [3:0] pos);
    logic [1:0] r;
    case (pos)
      4'd0, 4'd1, 4'd2: r = 2'd0;
      4'd3, 4'd4, 4'd5: r = 2'd1;
      4'd6, 4'd7, 4'd8: r = 2'd2;
      default:          r = 2'd0;
    endcase
    return r;
  endfunction

  // Column index (0 = left) of a cell index.
  function automatic logic [1:0] pos_col(input logic [3:0] pos);
    logic [1:0] c;
    case (pos)
      4'd0, 4'd3, 4'd6: c = 2'd0;
      4'd1, 4'd4, 4'd7: c = 2'd1;
      4'd2, 4'd5, 4'd8: c = 2'd2;
      default:          c = 2'd0;
    endcase
    return c;
  endfunction

  // True when the blank at pos can move in direction dir without leaving the board.
  function automatic logic dir_legal(input logic [1:0] dir, input logic [3:0] pos);
    logic ok;
    case (dir)
      DIR_L:   ok = (pos_col(pos) != 2'd0);
      DIR_R:   ok = (pos_col(pos) != 2'd2);
      DIR_U:   ok = (pos_row(pos) != 2'd0);
      DIR_D:   ok = (pos_row(pos) != 2'd2);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Scan seed, seed+1, seed+2, seed+3 and keep the first legal, non-reversing direction.
  // Every cell has at least two legal moves, so exactly one is always excluded at most.
  function automatic logic [1:0] pick_dir(input logic [1:0] seed, input logic [3:0] pos,
                                          input logic pv, input logic [1:0] pd);
    logic [1:0] cand;
    logic [1:0] pick;
    logic       found;
    found = 1'b0;
    pick  = seed;
    cand  = seed;
    for (int i = 0; i < 4; i++) begin
      cand = seed + 2'(i);
      if (!found && dir_legal(cand, pos) && !(pv && (cand == (pd ^ 2'b01)))) begin
        found = 1'b1;
        pick  = cand;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Cell index the blank moves into.
  function automatic logic [3:0] step_target(input logic [1:0] dir, input logic [3:0] pos);
    logic [3:0] t;
    case (dir)
      DIR_L:   t = pos - 4'd1;
      DIR_R:   t = pos + 4'd1;
      DIR_U:   t = pos - 4'd3;
      DIR_D:   t = pos + 4'd3;
      default: t = pos;
    endcase
    return t;
  endfunction

  // Choose this cycle's move and build the board that results from it.
  always_comb begin
    dir_s      = pick_dir(lfsr_r[1:0], blank_r, prev_valid_r, prev_dir_r);
    tgt_s      = step_target(dir_s, blank_r);
    tgt_tile_s = 4'h0;
    board_mv_s = board_r;
    for (int p = 0; p < 9; p++) begin
      if (4'(p) == tgt_s) begin
        tgt_tile_s = board_r[p];
      end else begin
        tgt_tile_s = tgt_tile_s;
      end
    end
    for (int p = 0; p < 9; p++) begin
      if (4'(p) == blank_r) begin
        board_mv_s[p] = tgt_tile_s;
      end else if (4'(p) == tgt_s) begin
        board_mv_s[p] = 4'h0;
      end else begin
        board_mv_s[p] = board_r[p];
      end
    end
  end

  // Next-state and control decode: start is only honoured in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    move_s      = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          load_s      = 1'b1;
          state_nxt_s = SHUFFLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHUFFLE: begin
        move_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          last_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHUFFLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Free-running LFSR, x^16+x^14+x^13+x^11+1, stepping in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
    end
  end

  // Board, blank position, move history and move counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      board_r      <= SOLVED;
      blank_r      <= BLANK_HOME;
      prev_dir_r   <= DIR_L;
      prev_valid_r <= 1'b0;
      cnt_r        <= '0;
    end else if (load_s) begin
      board_r      <= SOLVED;
      blank_r      <= BLANK_HOME;
      prev_dir_r   <= DIR_L;
      prev_valid_r <= 1'b0;
      cnt_r        <= '0;
    end else if (move_s) begin
      board_r      <= board_mv_s;
      blank_r      <= tgt_s;
      prev_dir_r   <= dir_s;
      prev_valid_r <= 1'b1;
      cnt_r        <= cnt_r + CNT_ONE;
    end else begin
      board_r      <= board_r;
      blank_r      <= blank_r;
      prev_dir_r   <= prev_dir_r;
      prev_valid_r <= prev_valid_r;
      cnt_r        <= cnt_r;
    end
  end

  // Status flags: busy spans the shuffle, done pulses once after the last move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= last_s;
      if (load_s) begin
        busy_r <= 1'b1;
      end else if (last_s) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign row1      = {board_r[0], board_r[1], board_r[2]};
  assign row2      = {board_r[3], board_r[4], board_r[5]};
  assign row3      = {board_r[6], board_r[7], board_r[8]};
  assign blank_pos = blank_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_puzzle_shuffler.sv
// Testbench for puzzle_shuffler: a 64-move instance and a 1-move instance share
// clock and reset. Moves are predicted by a board model that works on
// row/column arithmetic over a plain tile array, fed by a model LFSR.
module tb_puzzle_shuffler;

  localparam int N = 64;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] row1, row2, row3;
  logic [3:0]  blank_pos;
  logic        busy, done;
  logic        start1;
  logic [11:0] row1_1, row2_1, row3_1;
  logic [3:0]  blank_pos_1;
  logic        busy_1, done_1;

  int vecs = 0;
  int errs = 0;

  logic [15:0] m_lfsr;
  int m_board[9];
  int m_blank;
  int m_prev;

  puzzle_shuffler #(.N_MOVES(N), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .row1(row1), .row2(row2), .row3(row3),
    .blank_pos(blank_pos), .busy(busy), .done(done)
  );

  puzzle_shuffler #(.N_MOVES(1), .LFSR_SEED(16'hACE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .row1(row1_1), .row2(row2_1), .row3(row3_1),
    .blank_pos(blank_pos_1), .busy(busy_1), .done(done_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR, x^16+x^14+x^13+x^11+1 from seed ACE1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  task automatic model_solve();
    for (int p = 0; p < 8; p++) m_board[p] = p + 1;
    m_board[8] = 0;
    m_blank = 8;
    m_prev = -1;
  endtask

  // One blank move chosen from r, r+1, r+2, r+3 (mod 4).
  task automatic model_move(input logic [1:0] r);
    int row, col, d, pick, tgt;
    bit ok, found;
    row = m_blank / 3;
    col = m_blank % 3;
    found = 0;
    pick = 0;
    tgt = m_blank;
    for (int i = 0; i < 4; i++) begin
      if (!found) begin
        d = (int'(r) + i) % 4;
        ok = (d == 0 && col > 0) || (d == 1 && col < 2) || (d == 2 && row > 0) || (d == 3 && row < 2);
        if (ok && !(m_prev >= 0 && d == (m_prev ^ 1))) begin
          found = 1;
          pick = d;
          case (d)
            0: tgt = m_blank - 1;
            1: tgt = m_blank + 1;
            2: tgt = m_blank - 3;
            default: tgt = m_blank + 3;
          endcase
        end
      end
    end
    m_board[m_blank] = m_board[tgt];
    m_board[tgt] = 0;
    m_blank = tgt;
    m_prev = pick;
  endtask

  function automatic logic [35:0] model_rows();
    logic [35:0] v;
    v = '0;
    for (int p = 0; p < 9; p++) v[35 - 4*p -: 4] = 4'(m_board[p]);
    return v;
  endfunction

  function automatic bit is_perm(input logic [35:0] v);
    logic [15:0] seen;
    logic [3:0] nib;
    seen = '0;
    for (int p = 0; p < 9; p++) begin
      nib = v[4*p +: 4];
      seen[nib] = 1'b1;
    end
    return seen == 16'h01FF;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    vecs++;
    if ({row1, row2, row3} !== 36'h123456780) begin
      errs++; $display("FAIL reset_rows got %h want 123456780", {row1, row2, row3});
    end
    vecs++;
    if (blank_pos !== 4'd8 || busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL reset_flags got blank=%0d busy=%b done=%b want 8/0/0", blank_pos, busy, done);
    end
    vecs++;
    if ({row1_1, row2_1, row3_1} !== 36'h123456780 || busy_1 !== 1'b0 || done_1 !== 1'b0) begin
      errs++; $display("FAIL reset_dut1 got %h busy=%b done=%b", {row1_1, row2_1, row3_1}, busy_1, done_1);
    end
    vecs++;
    if (dut.lfsr_r !== 16'hACE1) begin
      errs++; $display("FAIL reset_lfsr got %h want ace1", dut.lfsr_r);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vecs++;
    if (dut.lfsr_r !== 16'h59C3) begin
      errs++; $display("FAIL lfsr_step got %h want 59c3", dut.lfsr_r);
    end
  endtask

  // One shuffle on the 64-move instance. poke_at: move index during which start is
  // pulsed again (0 = none). started: start is already high at entry. chain_out: leave
  // start high in the done cycle. abort_at: pull reset after that move (0 = none).
  task automatic run_shuffle(input int poke_at, input bit started, input bit chain_out,
                             input int abort_at);
    logic [35:0] exp_rows;
    logic [35:0] got_rows;
    int old_bp, step;
    if (!started) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_solve();
    vecs++;
    if (busy !== 1'b1 || {row1, row2, row3} !== 36'h123456780 || blank_pos !== 4'd8) begin
      errs++; $display("FAIL shuffle_load got busy=%b rows=%h blank=%0d", busy, {row1, row2, row3}, blank_pos);
    end
    for (int k = 1; k <= N; k++) begin
      old_bp = int'(blank_pos);
      model_move(m_lfsr[1:0]);
      if (k == poke_at) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      exp_rows = model_rows();
      got_rows = {row1, row2, row3};
      vecs++;
      if (got_rows !== exp_rows || int'(blank_pos) !== m_blank) begin
        errs++; $display("FAIL move_%0d got rows=%h blank=%0d want rows=%h blank=%0d",
                         k, got_rows, blank_pos, exp_rows, m_blank);
      end
      step = int'(blank_pos) - old_bp;
      vecs++;
      if (!is_perm(got_rows) || !(step == 1 || step == -1 || step == 3 || step == -3)) begin
        errs++; $display("FAIL legal_%0d got rows=%h step=%0d want permutation and one-cell step", k, got_rows, step);
      end
      vecs++;
      if (k < N) begin
        if (busy !== 1'b1 || done !== 1'b0) begin
          errs++; $display("FAIL busy_%0d got busy=%b done=%b want 1/0", k, busy, done);
        end
      end else begin
        if (busy !== 1'b0 || done !== 1'b1) begin
          errs++; $display("FAIL finish got busy=%b done=%b want 0/1", busy, done);
        end
      end
      if (k == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        vecs++;
        if ({row1, row2, row3} !== 36'h123456780 || blank_pos !== 4'd8 || busy !== 1'b0 || done !== 1'b0) begin
          errs++; $display("FAIL async_reset got rows=%h blank=%0d busy=%b done=%b",
                           {row1, row2, row3}, blank_pos, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    if (chain_out) begin
      start = 1'b1;
      return;
    end
    exp_rows = model_rows();
    @(negedge clk);
    vecs++;
    if (done !== 1'b0 || busy !== 1'b0 || {row1, row2, row3} !== exp_rows) begin
      errs++; $display("FAIL after_done got done=%b busy=%b rows=%h want 0/0/%h",
                       done, busy, {row1, row2, row3}, exp_rows);
    end
  endtask

  task automatic test_single_move();
    logic [1:0] r;
    for (int t = 0; t < 6; t++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      r = m_lfsr[1:0];
      @(negedge clk);
      vecs++;
      if (r == 2'd0 || r == 2'd3) begin
        if ({row1_1, row2_1, row3_1} !== 36'h123456708 || blank_pos_1 !== 4'd7) begin
          errs++; $display("FAIL single_move r=%0d got %h blank=%0d want 123456708 blank=7",
                           r, {row1_1, row2_1, row3_1}, blank_pos_1);
        end
      end else begin
        if ({row1_1, row2_1, row3_1} !== 36'h123450786 || blank_pos_1 !== 4'd5) begin
          errs++; $display("FAIL single_move r=%0d got %h blank=%0d want 123450786 blank=5",
                           r, {row1_1, row2_1, row3_1}, blank_pos_1);
        end
      end
      vecs++;
      if (busy_1 !== 1'b0 || done_1 !== 1'b1) begin
        errs++; $display("FAIL single_done got busy=%b done=%b want 0/1", busy_1, done_1);
      end
      @(negedge clk);
      vecs++;
      if (done_1 !== 1'b0) begin
        errs++; $display("FAIL single_pulse got done=%b want 0", done_1);
      end
    end
  endtask

  task automatic test_full_shuffle();
    for (int t = 0; t < 2; t++) begin
      repeat ($urandom_range(0, 9)) @(negedge clk);
      run_shuffle(0, 1'b0, 1'b0, 0);
    end
  endtask

  task automatic test_start_while_busy();
    repeat ($urandom_range(0, 9)) @(negedge clk);
    run_shuffle(10, 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid();
    repeat ($urandom_range(0, 9)) @(negedge clk);
    run_shuffle(0, 1'b0, 1'b0, 30);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errs++; $display("FAIL post_reset_idle got done=%b busy=%b want 0/0", done, busy);
      end
    end
    run_shuffle(0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    repeat ($urandom_range(0, 9)) @(negedge clk);
    run_shuffle(0, 1'b0, 1'b1, 0);
    run_shuffle(0, 1'b1, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_single_move();
    test_full_shuffle();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
